ddr_cmd_arbiter: RTL and testbench
==================================

// Module: ddr_cmd_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single DDR controller command port between NREQ
//  requesters (PCI target BAR1 path, DMA engines). Holds off all traffic until DDR
//  init_done, issues one burst at a time, waits for controller completion and
//  returns a per-requester done pulse. Sits in i_user between PCI-side logic and i_ddr.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  ADDR_W   24  DDR word address width
//  LEN_W    6   burst length field width, in words
//  TMO_W    12  watchdog width; timeout = 2^TMO_W-1 cycles; TMO_W=0 disables
//  PRIO0    1   1: requester 0 (PCI target) has strict priority over round-robin
// PORTS
//  PCI_CLK    in   1             clock (DDR controller command port on same clock)
//  PCI_RSTn   in   1             async active-low reset
//  init_done  in   1             DDR controller initialisation complete
//  req        in   NREQ          request per requester, level, held until done
//  req_rnw    in   NREQ          1=read, 0=write, per requester
//  req_addr   in   NREQ*ADDR_W   start address, requester i at [i*ADDR_W +: ADDR_W]
//  req_len    in   NREQ*LEN_W    burst length in words, requester i at [i*LEN_W +: LEN_W]
//  gnt        out  NREQ          one-hot grant, high from selection to completion
//  done       out  NREQ          1-cycle completion pulse to granted requester
//  cmd_valid  out  1             command valid to DDR controller
//  cmd_ready  in   1             controller accepts command when valid&&ready
//  cmd_rnw    out  1             latched direction
//  cmd_addr   out  ADDR_W        latched address
//  cmd_len    out  LEN_W         latched length
//  cmd_done   in   1             controller pulse: current burst finished
//  err        out  1             sticky watchdog error
// BEHAVIOUR
//  Reset: gnt=0, done=0, cmd_valid=0, cmd_rnw/addr/len=0, err=0, state INIT,
//   last-grant pointer=NREQ-1, so requester 0 wins the first tie.
//  States: INIT, IDLE, ISSUE, BUSY.
//  INIT: no grants. init_done=1 -> IDLE on the next edge.
//  IDLE: if init_done=0 -> INIT. Else if any req: winner = req[0] when PRIO0=1,
//   otherwise first set bit searching from last+1 with wrap NREQ-1 -> 0.
//   Next edge: gnt[winner]=1; latch rnw/addr/len; cmd_valid=1 -> ISSUE.
//   Latency: req sampled at edge N gives gnt and cmd_valid high after edge N+1.
//  len==0: granted, no cmd_valid; done pulses the cycle after gnt -> IDLE.
//  ISSUE: cmd_valid and cmd_* stay stable until cmd_ready.
//   On valid&&ready: cmd_valid=0 next cycle -> BUSY.
//  BUSY: on cmd_done: done[winner]=1 for one cycle, gnt=0 in the same cycle,
//   last=winner -> IDLE. At least one IDLE cycle separates any two grants.
//  Requester changes to req/addr/len after the latch edge are ignored until done.
//   Requester drops req on the cycle after done, else it is re-arbitrated as a
//   new request.
//  Watchdog: counter clears on ISSUE entry and counts in ISSUE and BUSY. At terminal
//   count: err=1 (sticky, reset only), cmd_valid=0, done[winner] pulses -> IDLE.
//   cmd_done on the terminal-count cycle: normal completion, err unchanged.
//  cmd_done outside BUSY: ignored. init_done falling in ISSUE/BUSY: burst completes
//   normally, then IDLE -> INIT.
//  Reset mid-operation: everything returns to reset values asynchronously; in-flight
//   burst abandoned, no done pulse.
//  gnt and done are always one-hot or zero; done never pulses without a prior gnt.
// TESTING
//  1 req[1]=1 with init_done=0 for 50 cycles -> gnt=0, cmd_valid=0; init_done=1 ->
//    gnt=4'b0010 two edges later.
//  2 PRIO0=0, req=4'b1111 held, cmd_ready=1, cmd_done 3 cycles after accept ->
//    grant order 0,1,2,3,0; each done pulse is exactly 1 cycle.
//  3 PRIO0=1, req=4'b0101 held -> only 0 granted; drop req[0] -> 2 granted next.
//  4 req[2] rnw=1 addr=24'h000100 len=8, cmd_ready low 5 cycles ->
//    cmd_valid held and fields stable; accept -> BUSY; cmd_done -> done=4'b0100.
//  5 TMO_W=4, never assert cmd_done -> done pulse and err=1 15 cycles after
//    ISSUE entry; next request still served; err stays 1.
//  6 PCI_RSTn low during BUSY -> all outputs 0 at once; after release -> INIT.

Source files
------------

// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter for the single DDR command port: grants one requester at a
// time, issues its latched burst, waits for completion and returns a done pulse.
module ddr_cmd_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 6,
    parameter int TMO_W  = 12,
    parameter bit PRIO0  = 1'b1
) (
    input  logic                   pci_clk_i,
    input  logic                   pci_rstn_i,
    input  logic                   init_done_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        req_rnw_i,
    input  logic [NREQ*ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*LEN_W-1:0]  req_len_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [NREQ-1:0]        done_o,
    output logic                   cmd_valid_o,
    input  logic                   cmd_ready_i,
    output logic                   cmd_rnw_o,
    output logic [ADDR_W-1:0]      cmd_addr_o,
    output logic [LEN_W-1:0]       cmd_len_o,
    input  logic                   cmd_done_i,
    output logic                   err_o
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic [IDX_W-1:0]  last_q, last_d, win_q, win_d;
    logic              valid_q, valid_d, rnw_q, rnw_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              tmo_hit, finish;

    logic [NREQ-1:0]   hi_mask, pool, sel_oh;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_rnw;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

    // Requesters above the last winner are searched first, then the wrap-around.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NREQ; i++) hi_mask[i] = (IDX_W'(i) > last_q);
        pool = ((req_i & hi_mask) != '0) ? (req_i & hi_mask) : req_i;
        if (PRIO0 && req_i[0]) pool = {{(NREQ-1){1'b0}}, 1'b1};
        sel_idx  = '0;
        sel_oh   = '0;
        sel_rnw  = 1'b0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (pool[i]) begin
                sel_idx   = IDX_W'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_rnw   = req_rnw_i[i];
                sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_len   = req_len_i[i*LEN_W +: LEN_W];
            end
        end
    end

    generate
        if (TMO_W > 0) begin : g_wd
            localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((64'd1 << TMO_W) - 64'd2);
            logic [TMO_W-1:0] tmo_q, tmo_d;
            // Cleared while idle, so every burst starts counting from zero.
            always_comb begin
                tmo_d = tmo_q;
                if (state_q == ST_ISSUE || state_q == ST_BUSY) tmo_d = tmo_q + 1'b1;
                else tmo_d = '0;
            end
            always_ff @(posedge pci_clk_i or negedge pci_rstn_i) begin
                if (!pci_rstn_i) tmo_q <= '0;
                else             tmo_q <= tmo_d;
            end
            assign tmo_hit = (tmo_q == TMO_LAST);
        end else begin : g_no_wd
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        last_d  = last_q;
        win_d   = win_q;
        valid_d = valid_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        len_d   = len_q;
        err_d   = err_q;
        finish  = 1'b0;
        case (state_q)
            ST_INIT: if (init_done_i) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!init_done_i) begin
                    state_d = ST_INIT;
                end else if (req_i != '0) begin
                    gnt_d   = sel_oh;
                    win_d   = sel_idx;
                    rnw_d   = sel_rnw;
                    addr_d  = sel_addr;
                    len_d   = sel_len;
                    valid_d = (sel_len != '0);
                    // Zero-length bursts skip the controller and complete next cycle.
                    state_d = (sel_len != '0) ? ST_ISSUE : ST_BUSY;
                end
            end
            ST_ISSUE: begin
                if (tmo_hit) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end else if (cmd_ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cmd_done_i || len_q == '0) begin
                    finish = 1'b1;
                end else if (tmo_hit) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (finish) begin
            done_d  = gnt_q;
            gnt_d   = '0;
            valid_d = 1'b0;
            last_d  = win_q;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge pci_clk_i or negedge pci_rstn_i) begin
        if (!pci_rstn_i) begin
            state_q <= ST_INIT;
            gnt_q   <= '0;
            done_q  <= '0;
            last_q  <= IDX_W'(NREQ-1);
            win_q   <= '0;
            valid_q <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            last_q  <= last_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign cmd_valid_o = valid_q;
    assign cmd_rnw_o   = rnw_q;
    assign cmd_addr_o  = addr_q;
    assign cmd_len_o   = len_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Bench for ddr_cmd_arbiter: directed scenarios plus randomized bursts checked
// against a transaction-level round-robin model; one round-robin and one priority instance.
module tb_ddr_cmd_arbiter;

    localparam int N  = 4;
    localparam int AW = 24;
    localparam int LW = 6;

    logic            clk;
    logic            rst_n;
    logic            init_done;
    logic [N-1:0]    req, req_rnw;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic            cmd_ready, cmd_done;

    logic [N-1:0]  gnt_rr, done_rr, gnt_pr, done_pr;
    logic          cv_rr, rnw_rr, err_rr, cv_pr, rnw_pr, err_pr;
    logic [AW-1:0] addr_rr, addr_pr;
    logic [LW-1:0] len_rr, len_pr;

    bit            use_pr;
    logic [N-1:0]  gnt_s, done_s;
    logic          cv_s, rnw_s, err_s;
    logic [AW-1:0] addr_s;
    logic [LW-1:0] len_s;

    int checks = 0;
    int errors = 0;
    int last;
    bit exp_err;

    ddr_cmd_arbiter #(.NREQ(N), .ADDR_W(AW), .LEN_W(LW), .TMO_W(4), .PRIO0(1'b0)) dut_rr (
        .pci_clk_i(clk), .pci_rstn_i(rst_n), .init_done_i(init_done),
        .req_i(req), .req_rnw_i(req_rnw), .req_addr_i(req_addr), .req_len_i(req_len),
        .gnt_o(gnt_rr), .done_o(done_rr), .cmd_valid_o(cv_rr), .cmd_ready_i(cmd_ready),
        .cmd_rnw_o(rnw_rr), .cmd_addr_o(addr_rr), .cmd_len_o(len_rr),
        .cmd_done_i(cmd_done), .err_o(err_rr)
    );

    ddr_cmd_arbiter #(.NREQ(N), .ADDR_W(AW), .LEN_W(LW), .TMO_W(4), .PRIO0(1'b1)) dut_pr (
        .pci_clk_i(clk), .pci_rstn_i(rst_n), .init_done_i(init_done),
        .req_i(req), .req_rnw_i(req_rnw), .req_addr_i(req_addr), .req_len_i(req_len),
        .gnt_o(gnt_pr), .done_o(done_pr), .cmd_valid_o(cv_pr), .cmd_ready_i(cmd_ready),
        .cmd_rnw_o(rnw_pr), .cmd_addr_o(addr_pr), .cmd_len_o(len_pr),
        .cmd_done_i(cmd_done), .err_o(err_pr)
    );

    assign gnt_s  = use_pr ? gnt_pr  : gnt_rr;
    assign done_s = use_pr ? done_pr : done_rr;
    assign cv_s   = use_pr ? cv_pr   : cv_rr;
    assign rnw_s  = use_pr ? rnw_pr  : rnw_rr;
    assign addr_s = use_pr ? addr_pr : addr_rr;
    assign len_s  = use_pr ? len_pr  : len_rr;
    assign err_s  = use_pr ? err_pr  : err_rr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  64'(gnt_s),  64'd0);
        chk({tag, "_done"}, 64'(done_s), 64'd0);
        chk({tag, "_cv"},   64'(cv_s),   64'd0);
        chk({tag, "_rnw"},  64'(rnw_s),  64'd0);
        chk({tag, "_addr"}, 64'(addr_s), 64'd0);
        chk({tag, "_len"},  64'(len_s),  64'd0);
        chk({tag, "_err"},  64'(err_s),  64'd0);
    endtask

    // Reference winner: requester 0 if it has priority, else first requester after the last winner.
    function automatic int model_winner();
        if (use_pr && req[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic new_req(input int i, input int len);
        req[i]               = 1'b1;
        req_rnw[i]           = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW] = AW'($urandom);
        req_len[i*LW +: LW]  = LW'(len);
    endtask

    // Called in the cycle the grant is expected; returns in the done-pulse cycle.
    // mode 0: accept after r cycles, cmd_done after d more; 1: cmd_done on the watchdog's
    // last cycle; 2: no cmd_done, watchdog fires 15 cycles after the grant.
    task automatic run_burst(input int exp_w, input int r, input int d, input int mode);
        logic [N-1:0]  oh;
        logic [LW-1:0] l;
        logic [AW-1:0] a;
        logic          rw;
        oh = N'(1 << exp_w);
        l  = req_len[exp_w*LW +: LW];
        a  = req_addr[exp_w*AW +: AW];
        rw = req_rnw[exp_w];
        chk("gnt", 64'(gnt_s), 64'(oh));
        chk("done_before_gnt", 64'(done_s), 64'd0);
        chk("cmd_valid", 64'(cv_s), 64'(l != '0));
        if (l != '0) begin
            chk("cmd_addr", 64'(addr_s), 64'(a));
            chk("cmd_len", 64'(len_s), 64'(l));
            chk("cmd_rnw", 64'(rnw_s), 64'(rw));
        end
        req_addr[exp_w*AW +: AW] = AW'($urandom);
        req_len[exp_w*LW +: LW]  = LW'($urandom);
        req_rnw[exp_w]           = ~rw;
        if (l == '0) begin
            step();
        end else if (mode == 0) begin
            for (int k = 0; k < r; k++) begin
                cmd_ready = 1'b0;
                cmd_done  = 1'($urandom_range(0, 1));
                step();
                chk("hold_valid", 64'(cv_s), 64'd1);
                chk("hold_addr", 64'(addr_s), 64'(a));
                chk("hold_len", 64'(len_s), 64'(l));
                chk("hold_rnw", 64'(rnw_s), 64'(rw));
            end
            cmd_done  = 1'b0;
            cmd_ready = 1'b1;
            step();
            cmd_ready = 1'b0;
            chk("valid_after_accept", 64'(cv_s), 64'd0);
            chk("gnt_busy", 64'(gnt_s), 64'(oh));
            for (int k = 0; k < d; k++) begin
                step();
                chk("done_early", 64'(done_s), 64'd0);
                chk("gnt_wait", 64'(gnt_s), 64'(oh));
            end
            cmd_done = 1'b1;
            step();
            cmd_done = 1'b0;
        end else begin
            cmd_ready = 1'b1;
            step();
            cmd_ready = 1'b0;
            chk("valid_after_accept", 64'(cv_s), 64'd0);
            for (int k = 2; k <= 14; k++) begin
                step();
                chk("done_before_tmo", 64'(done_s), 64'd0);
            end
            if (mode == 1) cmd_done = 1'b1;
            else           exp_err  = 1'b1;
            step();
            cmd_done = 1'b0;
        end
        chk("done_pulse", 64'(done_s), 64'(oh));
        chk("gnt_release", 64'(gnt_s), 64'd0);
        chk("valid_end", 64'(cv_s), 64'd0);
        chk("err", 64'(err_s), 64'(exp_err));
        last = exp_w;
    endtask

    task automatic do_reset(input bit pr);
        use_pr    = pr;
        rst_n     = 1'b0;
        req       = '0;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        init_done = 1'b1;
        #1;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();
        step();
        last    = N - 1;
        exp_err = 1'b0;
    endtask

    task automatic random_phase(input int n);
        int w;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0)
                    new_req(i, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 63)));
            end
            if (req == '0) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    chk("gnt_gap", 64'(gnt_s), 64'd0);
                end
                new_req(int'($urandom_range(0, N-1)), int'($urandom_range(0, 63)));
            end
            w = model_winner();
            step();
            run_burst(w, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 0);
            if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
        end
    endtask

    initial begin
        int order2[5];
        order2 = '{0, 1, 2, 3, 0};
        use_pr    = 1'b0;
        rst_n     = 1'b0;
        init_done = 1'b0;
        req       = '0;
        req_rnw   = '0;
        req_addr  = '0;
        req_len   = '0;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        last      = N - 1;
        exp_err   = 1'b0;

        // Held off until init_done, then granted two edges later
        step();
        chk_all_zero("reset0");
        rst_n = 1'b1;
        new_req(1, 4);
        for (int k = 0; k < 50; k++) begin
            step();
            chk("init_gnt", 64'(gnt_s), 64'd0);
            chk("init_valid", 64'(cv_s), 64'd0);
        end
        init_done = 1'b1;
        step();
        chk("init_gnt_edge1", 64'(gnt_s), 64'd0);
        step();
        run_burst(1, 0, 0, 0);
        req[1] = 1'b0;

        // All four requesting: round-robin order 0,1,2,3,0
        do_reset(1'b0);
        for (int i = 0; i < N; i++) new_req(i, 3 + i);
        for (int b = 0; b < 5; b++) begin
            step();
            run_burst(order2[b], 0, 2, 0);
        end

        // Strict priority for requester 0
        do_reset(1'b1);
        new_req(0, 5);
        new_req(2, 6);
        for (int b = 0; b < 3; b++) begin
            step();
            run_burst(0, 1, 1, 0);
        end
        req[0] = 1'b0;
        step();
        run_burst(2, 0, 1, 0);
        req[2] = 1'b0;

        // Backpressured read burst
        do_reset(1'b0);
        req[2]             = 1'b1;
        req_rnw[2]         = 1'b1;
        req_addr[2*AW +: AW] = 24'h000100;
        req_len[2*LW +: LW]  = 6'd8;
        step();
        run_burst(2, 5, 3, 0);
        req[2] = 1'b0;

        // cmd_done on the watchdog's last cycle, then a real timeout, then normal service
        new_req(1, 3);
        step();
        run_burst(1, 0, 0, 1);
        req[1] = 1'b0;
        new_req(0, 7);
        step();
        run_burst(0, 0, 0, 2);
        req[0] = 1'b0;
        new_req(3, 2);
        step();
        run_burst(3, 1, 1, 0);
        req[3] = 1'b0;

        // init_done falling mid-burst: burst completes, then arbiter waits in INIT
        new_req(1, 4);
        step();
        init_done = 1'b0;
        run_burst(1, 2, 2, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("reinit_gnt", 64'(gnt_s), 64'd0);
        end
        init_done = 1'b1;
        step();
        chk("reinit_gnt_edge1", 64'(gnt_s), 64'd0);
        step();
        run_burst(1, 1, 1, 0);
        req[1] = 1'b0;

        do_reset(1'b0);
        random_phase(40);
        do_reset(1'b1);
        random_phase(25);

        // Asynchronous reset during BUSY
        do_reset(1'b0);
        new_req(3, 5);
        step();
        chk("rst_gnt", 64'(gnt_s), 64'h8);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("rst_busy_valid", 64'(cv_s), 64'd0);
        rst_n     = 1'b0;
        init_done = 1'b0;
        #1;
        chk_all_zero("midrst");
        step();
        rst_n   = 1'b1;
        exp_err = 1'b0;
        last    = N - 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_gnt", 64'(gnt_s), 64'd0);
            chk("post_rst_done", 64'(done_s), 64'd0);
        end
        init_done = 1'b1;
        step();
        chk("post_rst_edge1", 64'(gnt_s), 64'd0);
        step();
        run_burst(3, 0, 0, 0);
        req[3] = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
